// File: rtl/cell_histogram_if.sv
// Stream bundle between the row-histogram stage, the cell accumulator and
// the block-normalisation stage.
interface cell_histogram_if #(
  parameter int BIN_WIDTH_IN  = 11,
  parameter int BINS          = 10,
  parameter int BIN_WIDTH_OUT = 14,
  parameter int COL_WIDTH     = 7
);
  logic                            in_valid;
  logic                            in_ready;
  logic [BIN_WIDTH_IN*BINS-1:0]    row_histogram;
  logic                            out_valid;
  logic                            out_ready;
  logic [BIN_WIDTH_OUT*BINS-1:0]   cell_histogram;
  logic [COL_WIDTH-1:0]            cell_col;

  modport master (
    output in_valid, row_histogram, out_ready,
    input  in_ready, out_valid, cell_histogram, cell_col
  );

  modport slave (
    input  in_valid, row_histogram, out_ready,
    output in_ready, out_valid, cell_histogram, cell_col
  );
endinterface

// File: rtl/cell_histogram.sv
// Sums CELL_ROWS raster-ordered row histograms per cell column into one cell
// histogram, keeping partial sums in a per-column buffer until the band's last row.
module cell_histogram #(
  parameter int BIN_WIDTH_IN  = 11,
  parameter int BINS          = 10,
  parameter int BIN_WIDTH_OUT = 14,
  parameter int CELL_ROWS     = 8,
  parameter int CELLS_PER_ROW = 80,
  parameter int COL_WIDTH     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  cell_histogram_if.slave   bus
);

  localparam int OUT_W     = BIN_WIDTH_OUT * BINS;
  localparam int ROW_WIDTH = (CELL_ROWS > 2) ? $clog2(CELL_ROWS) : 1;

  typedef enum logic [1:0] {S_FIRST, S_ACCUM, S_LAST} state_t;

  state_t                 state_reg, state_next;
  logic [COL_WIDTH-1:0]   col_cnt_reg, col_cnt_next;
  logic [ROW_WIDTH-1:0]   row_cnt_reg, row_cnt_next;

  logic [OUT_W-1:0]       part_mem [CELLS_PER_ROW];
  logic [OUT_W-1:0]       part_rd;
  logic [OUT_W-1:0]       sum;

  logic                   out_valid_reg;
  logic [OUT_W-1:0]       hist_reg;
  logic [COL_WIDTH-1:0]   col_reg;

  logic                   in_ready;
  logic                   acc;
  logic                   col_wrap;

  // Only the last row can be held up by the downstream stage.
  assign in_ready = (state_reg != S_LAST) || !out_valid_reg || bus.out_ready;
  assign acc      = bus.in_valid && in_ready;
  assign col_wrap = acc && (col_cnt_reg == COL_WIDTH'(CELLS_PER_ROW - 1));
  assign part_rd  = part_mem[col_cnt_reg];

  genvar gi;
  generate
    for (gi = 0; gi < BINS; gi++) begin : g_bin
      logic [BIN_WIDTH_OUT-1:0] base;
      // Row 0 ignores the buffer so the previous band's sums never leak in.
      assign base = (state_reg == S_FIRST) ? '0
                  : part_rd[gi*BIN_WIDTH_OUT +: BIN_WIDTH_OUT];
      assign sum[gi*BIN_WIDTH_OUT +: BIN_WIDTH_OUT] =
        base + BIN_WIDTH_OUT'(bus.row_histogram[gi*BIN_WIDTH_IN +: BIN_WIDTH_IN]);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    if (acc) begin
      if (col_wrap) begin
        col_cnt_next = '0;
        row_cnt_next = (row_cnt_reg == ROW_WIDTH'(CELL_ROWS - 1)) ? '0
                     : row_cnt_reg + 1'b1;
        case (state_reg)
          S_FIRST: state_next = (CELL_ROWS == 2) ? S_LAST : S_ACCUM;
          S_ACCUM: if (row_cnt_reg == ROW_WIDTH'(CELL_ROWS - 2)) state_next = S_LAST;
          S_LAST:  state_next = S_FIRST;
          default: state_next = S_FIRST;
        endcase
      end else begin
        col_cnt_next = col_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FIRST;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  // Partial-sum buffer is never reset; row 0 overwrites whatever is there.
  always_ff @(posedge clk) begin
    if (acc && state_reg != S_LAST) begin
      part_mem[col_cnt_reg] <= sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      hist_reg      <= '0;
      col_reg       <= '0;
    end else if (acc && state_reg == S_LAST) begin
      out_valid_reg <= 1'b1;
      hist_reg      <= sum;
      col_reg       <= col_cnt_reg;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_reg;
  assign bus.cell_histogram = hist_reg;
  assign bus.cell_col       = col_reg;

endmodule

// File: tb/tb_cell_histogram.sv
// Directed and random stimulus for cell_histogram, checked against a
// per-column cell-sum model derived from the input sequence index.
module tb_cell_histogram;
  localparam int BWI = 11;
  localparam int B   = 10;
  localparam int BWO = 14;
  localparam int R   = 8;
  localparam int C   = 4;
  localparam int CW  = 2;
  localparam int IW  = BWI * B;
  localparam int OW  = BWO * B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_histogram_if #(.BIN_WIDTH_IN(BWI), .BINS(B), .BIN_WIDTH_OUT(BWO), .COL_WIDTH(CW)) bus ();

  cell_histogram #(
    .BIN_WIDTH_IN(BWI), .BINS(B), .BIN_WIDTH_OUT(BWO),
    .CELL_ROWS(R), .CELLS_PER_ROW(C), .COL_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: input number n belongs to column n%C, band row (n/C)%R.
  int               msum [C][B];
  int               n_acc = 0;
  int               n_pushed = 0;
  int               n_popped = 0;
  logic [OW-1:0]    exp_q[$];
  int               exp_col_q[$];
  bit               rand_ready = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [IW-1:0] d, output bit is_last,
                              output logic [OW-1:0] o, output int col);
    int row;
    col = n_acc % C;
    row = (n_acc / C) % R;
    for (int k = 0; k < B; k++) begin
      int v;
      v = int'(d[k*BWI +: BWI]);
      msum[col][k] = (row == 0) ? v : msum[col][k] + v;
    end
    o = '0;
    for (int k = 0; k < B; k++) o[k*BWO +: BWO] = BWO'(msum[col][k]);
    is_last = (row == R - 1);
    if (is_last) begin
      exp_q.push_back(o);
      exp_col_q.push_back(col);
      n_pushed++;
    end
    n_acc++;
  endtask

  task automatic model_reset();
    n_acc = 0;
    exp_q.delete();
    exp_col_q.delete();
  endtask

  function automatic logic [IW-1:0] mk(input int b0, input int b3, input int b9);
    logic [IW-1:0] d;
    d = '0;
    d[0*BWI +: BWI] = BWI'(b0);
    d[3*BWI +: BWI] = BWI'(b3);
    d[9*BWI +: BWI] = BWI'(b9);
    return d;
  endfunction

  function automatic logic [IW-1:0] rand_hist();
    logic [IW-1:0] d;
    for (int k = 0; k < B; k++) d[k*BWI +: BWI] = BWI'($urandom_range(0, 2047));
    return d;
  endfunction

  function automatic logic [IW-1:0] all_max();
    logic [IW-1:0] d;
    for (int k = 0; k < B; k++) d[k*BWI +: BWI] = BWI'(2047);
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept (and after
  // the output-cycle check when the input closes a cell).
  task automatic send(input logic [IW-1:0] d);
    int waited;
    int row;
    int col;
    bit last;
    logic [OW-1:0] o;
    waited = 0;
    row = (n_acc / C) % R;
    bus.in_valid = 1'b1;
    bus.row_histogram = d;
    @(negedge clk);
    if (row != R - 1) check("in_ready_rows_0_6", bus.in_ready, 1);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_timeout", waited < 200, 1);
    @(posedge clk);
    model_accept(d, last, o, col);
    #1;
    bus.in_valid = 1'b0;
    if (last) begin
      @(negedge clk);
      check("latency_out_valid", bus.out_valid, 1);
      check("latency_cell_col", bus.cell_col, col);
      check("latency_hist", bus.cell_histogram, o);
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: consumed outputs are compared in order; stalled outputs must hold.
  bit               hold_pending = 0;
  logic [OW-1:0]    hold_hist;
  logic [CW-1:0]    hold_col;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_hist", bus.cell_histogram, hold_hist);
        check("hold_col", bus.cell_col, hold_col);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("out_col", bus.cell_col, exp_col_q.pop_front());
          check("out_hist", bus.cell_histogram, exp_q.pop_front());
          n_popped++;
        end
      end
      hold_pending = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      hold_hist = bus.cell_histogram;
      hold_col = bus.cell_col;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    bit last;
    int col;
    logic [OW-1:0] o;
    logic [IW-1:0] d;

    bus.in_valid = 1'b0;
    bus.row_histogram = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_hist", bus.cell_histogram, 0);
    check("reset_col", bus.cell_col, 0);
    @(posedge clk);
    #1;

    // Basic accumulation, maximum values, then a second band with new data.
    for (int i = 0; i < R * C; i++) send(mk(1, 2, 8));
    for (int i = 0; i < R * C; i++) send(all_max());
    for (int i = 0; i < R * C; i++) send(mk(5, 2, 8));

    // Backpressure on the last row.
    for (int i = 0; i < (R - 1) * C; i++) send(rand_hist());
    bus.out_ready = 1'b0;
    send(rand_hist());
    d = rand_hist();
    bus.in_valid = 1'b1;
    bus.row_histogram = d;
    @(negedge clk);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_col", bus.cell_col, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_in_ready_2", bus.in_ready, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    model_accept(d, last, o, col);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("reload_out_valid", bus.out_valid, 1);
    check("reload_col", bus.cell_col, col);
    check("reload_hist", bus.cell_histogram, o);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(rand_hist());
    bus.out_ready = 1'b0;
    send(rand_hist());

    // Next band rows 0..6 flow while the last output is held.
    for (int i = 0; i < (R - 1) * C; i++) send(rand_hist());
    bus.out_ready = 1'b1;
    for (int i = 0; i < C; i++) send(rand_hist());

    // Random data with random downstream readiness.
    rand_ready = 1;
    for (int i = 0; i < 2 * R * C; i++) send(rand_hist());
    rand_ready = 0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-band with an output pending.
    for (int i = 0; i < R * C - 1; i++) send(mk(3, 1, 7));
    bus.out_ready = 1'b0;
    send(mk(3, 1, 7));
    for (int i = 0; i < 3 * C; i++) send(rand_hist());
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_in_ready", bus.in_ready, 1);
    check("midreset_col", bus.cell_col, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < R * C; i++) send(mk(1, 2, 8));

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cell_histogram.md
Name: cell_histogram

Overview:
- Downstream of the per-row histogram stage.
- Accumulates CELL_ROWS consecutive row histograms belonging to the same cell column into one full cell histogram (9 orientation bins plus a 10th magnitude-sum bin).
- Row histograms arrive in raster order, one per cell column across the image row, so partial cell sums are held in a per-column buffer until the last row of the cell band.
- Emits one cell histogram per cell column to the block-normalisation stage.

Parameters:
BIN_WIDTH_IN, 11, width of each bin in the incoming row histogram
BINS, 10, bins per histogram (9 orientation + 1 magnitude sum)
BIN_WIDTH_OUT, 14, width of each accumulated cell bin (8 x 2047 = 16376 fits)
CELL_ROWS, 8, pixel rows per cell
CELLS_PER_ROW, 80, cell columns per image row (640 / 8)
COL_WIDTH, 7, width of the cell column index (ceil log2 CELLS_PER_ROW)

Ports:
clk  input  1  clock; all logic rising-edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  row_histogram valid
in_ready  output  1  block can accept row_histogram
row_histogram  input  BIN_WIDTH_IN*BINS  packed row histogram; bin k at [k*BIN_WIDTH_IN +: BIN_WIDTH_IN]
out_valid  output  1  cell_histogram valid
out_ready  input  1  downstream accepts cell_histogram
cell_histogram  output  BIN_WIDTH_OUT*BINS  packed cell histogram; bin k at [k*BIN_WIDTH_OUT +: BIN_WIDTH_OUT]
cell_col  output  COL_WIDTH  cell column index of the current cell_histogram

Behaviour:
- Interface: one clock (clk), synchronous active-low reset (rst_n). All state, including resets, updates on the rising edge of clk.
- Accept: `acc = in_valid && in_ready`.
- Counters:
  - col_cnt runs 0..CELLS_PER_ROW-1 and increments on acc.
  - When col_cnt wraps, it returns to 0 and the FSM advances one row.
  - row_cnt runs 0..CELL_ROWS-1.
- FSM states:
  - S_FIRST: row 0.
  - S_ACCUM: rows 1..CELL_ROWS-2.
  - S_LAST: row CELL_ROWS-1.
- FSM transitions:
  - S_FIRST -> S_ACCUM on the column wrap (or -> S_LAST if CELL_ROWS == 2).
  - S_ACCUM -> S_LAST on the column wrap when row_cnt == CELL_ROWS-2.
  - S_LAST -> S_FIRST on the column wrap.
- Partial-sum buffer: CELLS_PER_ROW entries x BIN_WIDTH_OUT*BINS, combinational read at col_cnt, written on acc.
- Per-bin sum: each input bin is zero-extended to BIN_WIDTH_OUT.
  - S_FIRST: sum = input (overwrites stale buffer contents).
  - S_ACCUM / S_LAST: sum = buf[col_cnt] + input.
  - No saturation; the widths guarantee no overflow.
- Writes:
  - S_FIRST / S_ACCUM: buf[col_cnt] <= sum.
  - S_LAST: sum is loaded into the output register, out_valid <= 1, cell_col <= col_cnt. The buffer entry is don't-care.
- Latency: cell_histogram is valid the cycle after the last-row row histogram of that column is accepted.
- Output register holds its value and cell_col stable while out_valid && !out_ready.
- out_valid clears on out_valid && out_ready unless a new S_LAST accept occurs in the same cycle. In that case the register reloads and out_valid stays 1 (full throughput).
- in_ready:
  - 1 in S_FIRST / S_ACCUM.
  - In S_LAST: !out_valid || out_ready.
  - Backpressure therefore stalls input only during the last row.
- Reset values: out_valid 0, cell_histogram 0, cell_col 0, in_ready 1, col_cnt 0, row_cnt 0, state S_FIRST. The buffer is not reset.
- Reset mid-frame: all partial sums are discarded. The next accepted input is treated as row 0, column 0, and any pending output is dropped.
- No frame-start input: the counters define framing. The image height must be a multiple of CELL_ROWS.

Test Plan:
1. Basic accumulation (CELLS_PER_ROW=4, CELL_ROWS=8, out_ready=1). Feed 32 row histograms, each with bin0=1, bin3=2, bin9=8, others 0 -> 4 outputs with bin0=8, bin3=16, bin9=64, others 0, and cell_col 0,1,2,3. Each out_valid asserts the cycle after that column's row-7 accept.
2. Max value. Every bin = 2047 for all 8 rows of one column -> every output bin = 16376, with no wrap.
3. Second cell band. Repeat scenario 1 immediately with bin0=5 -> output bin0=40, with no carry-over from the first band (row-0 overwrite).
4. Backpressure. Hold out_ready=0 after the first S_LAST output:
   - in_ready=0 on the next row-7 input.
   - cell_histogram and cell_col stay stable.
   - Raising out_ready for one cycle accepts the stalled input in that same cycle, and out_valid remains 1 with the new value.
5. Non-last-row flow under backpressure. out_ready=0 with out_valid=1 while in rows 0..6 -> in_ready=1 and accumulation continues unaffected.
6. Reset mid-operation. Assert rst_n=0 for 1 cycle after 3 rows have been accumulated:
   - out_valid=0.
   - The next 32 inputs reproduce scenario 1 outputs exactly.
